// File: rtl/muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_sched
// Purpose : EX-stage sequencer for the pipelined multiplier and the iterative
//           divider, with a one-entry quotient/remainder cache.
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_is_div,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  input  logic        next_rdy,
  output logic        eu_stall,
  output logic        res_valid,
  output logic [31:0] res,
  output logic        mul_en,
  output logic        mul_signed,
  input  logic [63:0] mul_out,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_abort,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  localparam int              CW        = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0]   C_MUL_LAT = CW'(MUL_LAT);
  localparam logic [CW-1:0]   C_ONE     = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_op;
  logic [31:0]   r_pa;
  logic [31:0]   r_pb;
  logic [31:0]   r_res;
  logic          r_cache_valid;
  logic          r_cache_signed;
  logic [31:0]   r_cache_a;
  logic [31:0]   r_cache_b;
  logic [31:0]   r_cache_q;
  logic [31:0]   r_cache_r;

  logic w_accept;
  logic w_req_div_signed;
  logic w_cache_hit;
  logic w_mul_hi;

  assign w_accept         = (r_state == S_IDLE) & req_valid & ~flush & ~rst;
  assign w_req_div_signed = ~req_op[1];
  assign w_cache_hit      = r_cache_valid & (req_a == r_cache_a) & (req_b == r_cache_b)
                          & (w_req_div_signed == r_cache_signed);
  // HI and HIU select the upper product word; op 3 falls back to LO.
  assign w_mul_hi         = (r_op == 2'd1) | (r_op == 2'd2);

  assign mul_en     = w_accept & ~req_is_div;
  assign mul_signed = mul_en & (req_op != 2'd2);
  assign div_start  = w_accept & req_is_div & ~w_cache_hit;
  assign div_signed = div_start & w_req_div_signed;
  assign div_abort  = (r_state == S_DIV_WAIT) & flush & ~rst;
  assign res_valid  = (r_state == S_DONE);
  assign res        = r_res;
  assign eu_stall   = req_valid & ~flush & ~res_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_op           <= '0;
      r_pa           <= '0;
      r_pb           <= '0;
      r_res          <= '0;
      r_cache_valid  <= 1'b0;
      r_cache_signed <= 1'b0;
      r_cache_a      <= '0;
      r_cache_b      <= '0;
      r_cache_q      <= '0;
      r_cache_r      <= '0;
    end else if (flush) begin
      // Cache is deliberately left intact; a coincident div_done is dropped.
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op <= req_op;
            r_pa <= req_a;
            r_pb <= req_b;
            if (!req_is_div) begin
              r_cnt   <= C_MUL_LAT;
              r_state <= S_MUL_WAIT;
            end else if (w_cache_hit) begin
              r_res   <= req_op[0] ? r_cache_r : r_cache_q;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DIV_WAIT;
            end
          end
        end
        S_MUL_WAIT: begin
          if (r_cnt == C_ONE) begin
            r_res   <= w_mul_hi ? mul_out[63:32] : mul_out[31:0];
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - C_ONE;
          end
        end
        S_DIV_WAIT: begin
          if (div_done) begin
            r_res          <= r_op[0] ? div_r : div_q;
            r_cache_valid  <= 1'b1;
            r_cache_signed <= ~r_op[1];
            r_cache_a      <= r_pa;
            r_cache_b      <= r_pb;
            r_cache_q      <= div_q;
            r_cache_r      <= div_r;
            r_state        <= S_DONE;
          end
        end
        S_DONE: begin
          if (next_rdy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_sched
// Purpose : Directed self-checking bench for muldiv_sched.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_sched;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_is_div;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        next_rdy;
  logic        eu_stall;
  logic        res_valid;
  logic [31:0] res;
  logic        mul_en;
  logic        mul_signed;
  logic [63:0] mul_out;
  logic        div_start;
  logic        div_signed;
  logic        div_abort;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_sched #(.MUL_LAT(MUL_LAT)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_is_div (req_is_div),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .next_rdy   (next_rdy),
    .eu_stall   (eu_stall),
    .res_valid  (res_valid),
    .res        (res),
    .mul_en     (mul_en),
    .mul_signed (mul_signed),
    .mul_out    (mul_out),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_abort  (div_abort),
    .div_q      (div_q),
    .div_r      (div_r),
    .div_done   (div_done)
  );

  // Two-stage multiplier model: product visible MUL_LAT cycles after mul_en.
  logic [63:0] r_p0 = '0;
  logic [63:0] r_p1 = '0;
  always @(posedge clk) begin
    if (mul_en)
      r_p0 <= mul_signed ? ({{32{req_a[31]}}, req_a} * {{32{req_b[31]}}, req_b})
                         : ({32'd0, req_a} * {32'd0, req_b});
    r_p1 <= r_p0;
  end
  assign mul_out = r_p1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] exp_res);
    tick();
    req_valid = 1'b1; req_is_div = 1'b0; req_op = op; req_a = a; req_b = b;
    #1;
    check("mul_en_c0", 32'(mul_en), 32'd1);
    check("mul_signed", 32'(mul_signed), 32'(sgn));
    check("stall_c0", 32'(eu_stall), 32'd1);
    tick(); #1;
    check("stall_c1", 32'(eu_stall), 32'd1);
    check("mul_en_c1", 32'(mul_en), 32'd0);
    tick(); #1;
    check("stall_c2", 32'(eu_stall), 32'd1);
    check("valid_c2", 32'(res_valid), 32'd0);
    tick(); #1;
    check("valid_c3", 32'(res_valid), 32'd1);
    check("mul_res", res, exp_res);
    check("stall_c3", 32'(eu_stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_div = 1'b0; req_op = 2'd0;
    req_a = '0; req_b = '0; flush = 1'b0; next_rdy = 1'b1;
    div_q = '0; div_r = '0; div_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_stall", 32'(eu_stall), 32'd0);
    check("rst_mul_en", 32'(mul_en), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);

    // Multiplies, issued back to back
    run_mul(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFA);
    run_mul(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE);
    run_mul(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
    run_mul(2'd3, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);

    // Signed Q 100/7, divider completes in cycle 33
    tick();
    req_valid = 1'b1; req_is_div = 1'b1; req_op = 2'd0; req_a = 32'd100; req_b = 32'd7;
    #1;
    check("div_start_q", 32'(div_start), 32'd1);
    check("div_signed_q", 32'(div_signed), 32'd1);
    check("div_mul_en", 32'(mul_en), 32'd0);
    repeat (32) tick();
    div_done = 1'b1; div_q = 32'd14; div_r = 32'd2;
    #1;
    check("div_wait_valid", 32'(res_valid), 32'd0);
    check("div_wait_stall", 32'(eu_stall), 32'd1);
    tick();
    div_done = 1'b0;
    #1;
    check("div_q_valid", 32'(res_valid), 32'd1);
    check("div_q_res", res, 32'd14);

    // R on same operands hits the cache
    tick();
    req_op = 2'd1;
    #1;
    check("hit_no_start", 32'(div_start), 32'd0);
    check("hit_stall_c0", 32'(eu_stall), 32'd1);
    tick(); #1;
    check("hit_valid_c1", 32'(res_valid), 32'd1);
    check("hit_res", res, 32'd2);

    // RU misses (signedness differs), then flushed 5 cycles after start
    tick();
    req_op = 2'd3;
    #1;
    check("ru_start", 32'(div_start), 32'd1);
    check("ru_signed", 32'(div_signed), 32'd0);
    repeat (5) tick();
    flush = 1'b1;
    #1;
    check("abort_pulse", 32'(div_abort), 32'd1);
    check("flush_stall", 32'(eu_stall), 32'd0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    div_done = 1'b1; div_q = 32'd99; div_r = 32'd99;
    #1;
    check("abort_once", 32'(div_abort), 32'd0);
    check("late_done_valid", 32'(res_valid), 32'd0);
    tick();
    div_done = 1'b0;
    #1;
    check("late_done_valid2", 32'(res_valid), 32'd0);

    // RU again: still a miss; complete it into a stalled downstream
    tick();
    req_valid = 1'b1; req_op = 2'd3; next_rdy = 1'b0;
    #1;
    check("ru_miss_again", 32'(div_start), 32'd1);
    repeat (2) tick();
    div_done = 1'b1; div_q = 32'd14; div_r = 32'd2;
    tick();
    div_done = 1'b0;
    #1;
    check("hold_valid", 32'(res_valid), 32'd1);
    check("hold_res", res, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("hold_res_n", res, 32'd2);
      check("hold_valid_n", 32'(res_valid), 32'd1);
      check("hold_stall_n", 32'(eu_stall), 32'd0);
      check("hold_no_start", 32'(div_start), 32'd0);
    end
    tick();
    next_rdy = 1'b1;
    #1;
    check("release_valid", 32'(res_valid), 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    check("idle_after_release", 32'(res_valid), 32'd0);

    // RU now cached
    tick();
    req_valid = 1'b1;
    #1;
    check("ru_hit_no_start", 32'(div_start), 32'd0);
    tick(); #1;
    check("ru_hit_res", res, 32'd2);

    // Reset in the middle of a multiply
    tick();
    req_is_div = 1'b0; req_op = 2'd0; req_a = 32'd5; req_b = 32'd6;
    #1;
    check("mul2_en", 32'(mul_en), 32'd1);
    tick();
    rst = 1'b1; req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_valid", 32'(res_valid), 32'd0);
    check("mrst_res", res, 32'd0);
    check("mrst_stall", 32'(eu_stall), 32'd0);
    check("mrst_mul_en", 32'(mul_en), 32'd0);
    check("mrst_abort", 32'(div_abort), 32'd0);
    tick(); #1;
    check("mrst_no_done", 32'(res_valid), 32'd0);
    tick();
    req_valid = 1'b1; req_is_div = 1'b1; req_op = 2'd3; req_a = 32'd100; req_b = 32'd7;
    #1;
    check("mrst_cache_miss", 32'(div_start), 32'd1);
    tick();
    flush = 1'b1; req_valid = 1'b0;
    tick();
    flush = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_sched.md
# muldiv_sched

Sequencing controller for the execute stage's long-latency units: the pipelined multiplier and the iterative divider. It accepts one mul/div instruction at a time from EX, starts the correct unit, counts or waits for completion, selects and holds the 32-bit result until the downstream stage accepts it, and drives EX's stall. It also keeps a one-entry quotient/remainder cache so a DIV/MOD pair on identical operands costs one cycle. It sits beside the ALU/BRU in EX, and its result feeds EX's result mux.

## Interface
Parameters:
- MUL_LAT, 2, cycles from mul_en to a valid mul_out (≥1)

Ports (reset is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  EX holds a valid mul/div instruction
- req_is_div  in  1  1 = divide, 0 = multiply
- req_op  in  2  mul: 0 LO signed, 1 HI signed, 2 HIU unsigned, 3 treated as LO; div: 0 Q signed, 1 R signed, 2 QU, 3 RU
- req_a, req_b  in  32  forwarded rj / rkd operands
- flush  in  1  kill the EX instruction
- next_rdy  in  1  MEM1 can accept
- eu_stall  out  1  EX must hold
- res_valid  out  1  res is final for the EX instruction
- res  out  32  selected result
- mul_en, mul_signed  out  1  multiplier start pulse and signedness
- mul_out  in  64  multiplier product
- div_start, div_signed, div_abort  out  1  divider start pulse, signedness, cancel pulse
- div_q, div_r  in  32  divider results
- div_done  in  1  divider one-cycle completion pulse

Operands for both units are taken combinationally from req_a/req_b. Each unit latches them on its start pulse.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE: an instruction is accepted when req_valid & ~flush.
  - Multiply: pulse mul_en, load cnt = MUL_LAT, go to MUL_WAIT.
  - Divide, cache hit (cache_valid and a, b, signedness all equal): capture q or r from the cache into res, go to DONE. No div_start.
  - Divide, cache miss: pulse div_start, go to DIV_WAIT.
- MUL_WAIT: cnt decrements each cycle. When cnt == 1, capture mul_out[31:0] (LO) or mul_out[63:32] (HI/HIU) into res and go to DONE.
- DIV_WAIT: on div_done, capture q (Q/QU) or r (R/RU) into res, write {a, b, signed, q, r} to the cache, set cache_valid, go to DONE.
- DONE: res_valid = 1.
  - next_rdy = 1: go to IDLE. The instruction leaves EX this cycle.
  - next_rdy = 0: stay in DONE and hold res.
- eu_stall = req_valid & ~flush & ~res_valid.
- Signedness: mul_signed = (op != HIU); div_signed = op ∈ {Q, R}.
- Divide by zero: the divider output is passed through unchanged and is cacheable.
- Flush takes priority in every state:
  - Next state is IDLE and cnt clears.
  - In DIV_WAIT, div_abort pulses in the flush cycle.
  - A div_done in the same cycle as flush is discarded and the cache is not written.
  - Cache contents survive flush.
- Reset: state IDLE, cnt 0, cache_valid 0, res 0, and all outputs 0.

## Timing
- Multiply accepted in cycle 0: mul_en in cycle 0, res_valid from cycle MUL_LAT+1. For MUL_LAT = 2 that is cycle 3.
- Divide cache hit: accepted in cycle 0, res_valid in cycle 1.
- Divide miss: div_done in cycle N gives res_valid in cycle N+1.
- With next_rdy = 1 in DONE, IDLE follows in the next cycle and can accept a new req_valid in that cycle. This gives back-to-back issue with no bubble beyond the latency.
- Only one operation is in flight at any time. mul_en and div_start are never asserted together.

## Test plan
- Signed multiply LO: a = 0xFFFF_FFFE (−2), b = 3, MUL_LAT = 2 → eu_stall for cycles 0–2; res = 0xFFFF_FFFA with res_valid in cycle 3.
- HIU vs HI: a = b = 0xFFFF_FFFF → HIU gives 0xFFFF_FFFE, HI gives 0x0000_0000. Check mul_signed is 0 and 1 respectively.
- Divide then cache hit: Q with a = 100, b = 7, div_done after 33 cycles → res = 14. The following R on the same operands gives res = 2 with res_valid in cycle 1 and no div_start. A following RU on the same operands misses the cache and pulses div_start.
- Flush during DIV_WAIT: assert flush 5 cycles after start → div_abort pulses once; IDLE next cycle; a later div_done is ignored; res_valid stays 0; the cache is not updated.
- Downstream stall: reach DONE with next_rdy = 0 for 4 cycles → res held stable, eu_stall = 0, no new start. When next_rdy rises, IDLE follows next cycle.
- Reset mid-MUL_WAIT: rst asserted → next cycle state IDLE, all outputs 0, cache_valid 0. A subsequent divide misses the cache.
